// File: rtl/quant_block4_pkg.sv
// Shared quantizer types: zigzag tables, fixed-point constants,
// per-coefficient parameter bundle, coefficient type and FSM states.
package quant_pkg;

    localparam int COEF_W    = 16;
    localparam int NCOEF     = 16;
    localparam int QFIX      = 17;
    localparam int MAX_LEVEL = 2047;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic [3:0]               idx_t;

    // zigzag position -> raster index
    localparam idx_t ZIGZAG [NCOEF] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    // raster index -> zigzag position
    localparam idx_t ZIGZAG_INV [NCOEF] = '{
        4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd4, 4'd7, 4'd12,
        4'd3, 4'd8, 4'd11, 4'd13, 4'd9, 4'd10, 4'd14, 4'd15
    };

    typedef struct packed {
        logic [15:0] q;
        logic [16:0] iq;
        logic [31:0] bias;
        logic [31:0] zthr;
        logic [15:0] sharpen;
    } qparam_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/quant_block4_if.sv
// Request/result bundle of the 4x4 quantizer.
// master: block requester; slave: quant_block4.
interface quant_block4_if;

    logic         start;
    logic [255:0] coeffs;
    logic [255:0] sharpen;
    logic [15:0]  q_dc;
    logic [15:0]  q_ac;
    logic [16:0]  iq_dc;
    logic [16:0]  iq_ac;
    logic [31:0]  bias_dc;
    logic [31:0]  bias_ac;
    logic [31:0]  zthr_dc;
    logic [31:0]  zthr_ac;
    logic [255:0] levels;
    logic [255:0] out_coeffs;
    logic         nz;
    logic [3:0]   last_pos;
    logic         busy;
    logic         done;

    modport master (
        output start, coeffs, sharpen, q_dc, q_ac, iq_dc, iq_ac,
        output bias_dc, bias_ac, zthr_dc, zthr_ac,
        input  levels, out_coeffs, nz, last_pos, busy, done
    );

    modport slave (
        input  start, coeffs, sharpen, q_dc, q_ac, iq_dc, iq_ac,
        input  bias_dc, bias_ac, zthr_dc, zthr_ac,
        output levels, out_coeffs, nz, last_pos, busy, done
    );

endinterface

// File: rtl/quant_coeff_pe.sv
// Two-stage single-coefficient quantizer: stage 1 registers magnitude
// product and keep flag, stage 2 (combinational here) rounds, clamps, signs.
// Ports: clk, rst, in_valid/n_in/j_in/c/p in; out_valid/out_n/out_j/lvl/dq out.
module quant_coeff_pe
    import quant_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  idx_t    n_in,
    input  idx_t    j_in,
    input  coef_t   c,
    input  qparam_t p,
    output logic    out_valid,
    output idx_t    out_n,
    output idx_t    out_j,
    output coef_t   lvl,
    output coef_t   dq
);

    logic [16:0] abs_c;
    logic [16:0] mag;

    logic        s1_valid;
    logic        s1_sign;
    logic        s1_keep;
    logic [33:0] s1_prod;
    logic [15:0] s1_q;
    logic [31:0] s1_bias;
    idx_t        s1_n;
    idx_t        s1_j;

    logic [17:0] sh;
    logic [10:0] mag_l;
    logic [15:0] lmag;
    logic [15:0] lvl_u;
    logic [15:0] dq_u;

    // 17-bit magnitude: -32768 maps cleanly to 32768
    assign abs_c = c[15] ? 17'(17'd0 - {c[15], c}) : {1'b0, c};
    assign mag   = abs_c + {1'b0, p.sharpen};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_keep  <= 1'b0;
            s1_prod  <= '0;
            s1_q     <= '0;
            s1_bias  <= '0;
            s1_n     <= '0;
            s1_j     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_sign  <= c[15];
            s1_keep  <= {15'd0, mag} > p.zthr;
            s1_prod  <= 34'(mag) * 34'(p.iq);
            s1_q     <= p.q;
            s1_bias  <= p.bias;
            s1_n     <= n_in;
            s1_j     <= j_in;
        end
    end

    // Rounded quotient fits in 18 bits: (2^34 + 2^32) >> 17
    assign sh    = 18'(({1'b0, s1_prod} + {3'd0, s1_bias}) >> QFIX);
    assign mag_l = (sh > 18'(MAX_LEVEL)) ? 11'(MAX_LEVEL) : sh[10:0];
    assign lmag  = s1_keep ? {5'd0, mag_l} : 16'd0;
    assign lvl_u = s1_sign ? 16'(16'd0 - lmag) : lmag;
    // Low 16 bits of the product are sign-agnostic
    assign dq_u  = lvl_u * s1_q;

    assign out_valid = s1_valid;
    assign out_n     = s1_n;
    assign out_j     = s1_j;
    assign lvl       = coef_t'(lvl_u);
    assign dq        = coef_t'(dq_u);

endmodule

// File: rtl/quant_block4.sv
// 4x4 block quantizer: captures a block, streams it in zigzag order through
// quant_coeff_pe and writes levels (zigzag) / dequantized coeffs (raster).
// Ports: clk, rst, bus (quant_block4_if.slave).
module quant_block4
    import quant_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    quant_block4_if.slave bus
);

    state_t       state;
    idx_t         cnt;
    logic [255:0] coeffs_r;
    logic [255:0] sharpen_r;
    logic [15:0]  q_dc_r, q_ac_r;
    logic [16:0]  iq_dc_r, iq_ac_r;
    logic [31:0]  bias_dc_r, bias_ac_r;
    logic [31:0]  zthr_dc_r, zthr_ac_r;

    logic [255:0] levels_r;
    logic [255:0] out_coeffs_r;
    logic         nz_r;
    idx_t         last_pos_r;
    logic         busy_r;
    logic         done_r;

    idx_t    j;
    logic    issue;
    coef_t   c;
    qparam_t p;

    logic  pe_valid;
    idx_t  pe_n;
    idx_t  pe_j;
    coef_t pe_lvl;
    coef_t pe_dq;

    always_comb begin
        j         = ZIGZAG[cnt];
        issue     = (state == RUN);
        c         = coeffs_r[16*j +: 16];
        p         = '0;
        p.sharpen = sharpen_r[16*j +: 16];
        if (j == 4'd0) begin
            p.q    = q_dc_r;
            p.iq   = iq_dc_r;
            p.bias = bias_dc_r;
            p.zthr = zthr_dc_r;
        end else begin
            p.q    = q_ac_r;
            p.iq   = iq_ac_r;
            p.bias = bias_ac_r;
            p.zthr = zthr_ac_r;
        end
    end

    quant_coeff_pe u_pe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .n_in      (cnt),
        .j_in      (j),
        .c         (c),
        .p         (p),
        .out_valid (pe_valid),
        .out_n     (pe_n),
        .out_j     (pe_j),
        .lvl       (pe_lvl),
        .dq        (pe_dq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            coeffs_r     <= '0;
            sharpen_r    <= '0;
            q_dc_r       <= '0;
            q_ac_r       <= '0;
            iq_dc_r      <= '0;
            iq_ac_r      <= '0;
            bias_dc_r    <= '0;
            bias_ac_r    <= '0;
            zthr_dc_r    <= '0;
            zthr_ac_r    <= '0;
            levels_r     <= '0;
            out_coeffs_r <= '0;
            nz_r         <= 1'b0;
            last_pos_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        coeffs_r     <= bus.coeffs;
                        sharpen_r    <= bus.sharpen;
                        q_dc_r       <= bus.q_dc;
                        q_ac_r       <= bus.q_ac;
                        iq_dc_r      <= bus.iq_dc;
                        iq_ac_r      <= bus.iq_ac;
                        bias_dc_r    <= bus.bias_dc;
                        bias_ac_r    <= bus.bias_ac;
                        zthr_dc_r    <= bus.zthr_dc;
                        zthr_ac_r    <= bus.zthr_ac;
                        levels_r     <= '0;
                        out_coeffs_r <= '0;
                        nz_r         <= 1'b0;
                        last_pos_r   <= '0;
                        busy_r       <= 1'b1;
                        cnt          <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= FLUSH;
                    end
                end
                // Two drain cycles: last write-back, then done
                FLUSH: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (pe_valid) begin
                levels_r[16*pe_n +: 16]     <= pe_lvl;
                out_coeffs_r[16*pe_j +: 16] <= pe_dq;
                if (pe_lvl != '0) begin
                    nz_r       <= 1'b1;
                    last_pos_r <= pe_n;
                end
            end
        end
    end

    assign bus.levels     = levels_r;
    assign bus.out_coeffs = out_coeffs_r;
    assign bus.nz         = nz_r;
    assign bus.last_pos   = last_pos_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_quant_block4.sv
// Scoreboard bench for quant_block4: directed blocks push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_quant_block4;
    import quant_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    quant_block4_if bus ();

    quant_block4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [255:0] lv;
        logic [255:0] oc;
        logic         nz;
        logic [3:0]   lp;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   start_cyc = 0;
    int   done_count = 0;
    logic busy_q = 1'b0;

    task automatic check(string nm, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] put(logic [255:0] v, int idx,
                                         logic [15:0] x);
        logic [255:0] r;
        r = v;
        r[16*idx +: 16] = x;
        return r;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (bus.busy && !busy_q) start_cyc = ncyc;
        busy_q = bus.busy;
        if (bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
                e = sb.pop_front();
                check({e.name, "_levels"}, bus.levels, e.lv);
                check({e.name, "_out_coeffs"}, bus.out_coeffs, e.oc);
                check({e.name, "_nz"}, bus.nz, e.nz);
                check({e.name, "_last_pos"}, bus.last_pos, e.lp);
                check({e.name, "_latency"}, ncyc - start_cyc, 18);
                check({e.name, "_busy_at_done"}, bus.busy, 0);
            end
        end
    end

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.coeffs  = '0;
        bus.sharpen = '0;
        bus.q_dc    = '0;
        bus.q_ac    = '0;
        bus.iq_dc   = '0;
        bus.iq_ac   = '0;
        bus.bias_dc = '0;
        bus.bias_ac = '0;
        bus.zthr_dc = '0;
        bus.zthr_ac = '0;
    endtask

    task automatic issue(exp_t e);
        @(negedge clk);
        sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check({nm, "_completed"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic vec_dc100(logic [15:0] cv);
        clear_inputs();
        bus.coeffs[15:0] = cv;
        bus.q_dc         = 16'd10;
        bus.iq_dc        = 17'd13107;
        bus.bias_dc      = 32'd65536;
    endtask

    task automatic vec_c15(logic [31:0] zt);
        clear_inputs();
        bus.coeffs[16*15 +: 16] = 16'd5;
        bus.zthr_ac             = zt;
        bus.q_ac                = 16'd1;
        bus.iq_ac               = 17'd131071;
        bus.bias_ac             = 32'd65536;
    endtask

    task automatic vec_mixed();
        clear_inputs();
        bus.coeffs[16*1 +: 16]  = 16'hFFEC;
        bus.sharpen[16*1 +: 16] = 16'd5;
        bus.coeffs[16*8 +: 16]  = 16'd7;
        bus.coeffs[16*12 +: 16] = 16'h8000;
        bus.q_ac                = 16'd4;
        bus.iq_ac               = 17'd32768;
    endtask

    initial begin
        exp_t e;
        int   d0;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_levels", bus.levels, 0);
        check("rst_out_coeffs", bus.out_coeffs, 0);
        check("rst_nz", bus.nz, 0);
        check("rst_last_pos", bus.last_pos, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);

        vec_dc100(16'd100);
        e = '{lv: put('0, 0, 16'd10), oc: put('0, 0, 16'd100),
              nz: 1'b1, lp: 4'd0, name: "dc_pos"};
        issue(e);
        drain("dc_pos");

        clear_inputs();
        e = '{lv: '0, oc: '0, nz: 1'b0, lp: 4'd0, name: "zero"};
        issue(e);
        drain("zero");

        vec_dc100(16'hFF9C);
        e = '{lv: put('0, 0, 16'hFFF6), oc: put('0, 0, 16'hFF9C),
              nz: 1'b1, lp: 4'd0, name: "dc_neg"};
        issue(e);
        drain("dc_neg");

        clear_inputs();
        bus.coeffs[16*4 +: 16] = 16'd32767;
        bus.q_ac               = 16'd1;
        bus.iq_ac              = 17'd131071;
        e = '{lv: put('0, 2, 16'd2047), oc: put('0, 4, 16'd2047),
              nz: 1'b1, lp: 4'd2, name: "clamp"};
        issue(e);
        drain("clamp");

        vec_c15(32'd5);
        e = '{lv: '0, oc: '0, nz: 1'b0, lp: 4'd0, name: "zthr_eq"};
        issue(e);
        drain("zthr_eq");

        vec_c15(32'd4);
        e = '{lv: put('0, ZIGZAG_INV[15], 16'd5), oc: put('0, 15, 16'd5),
              nz: 1'b1, lp: 4'd15, name: "zthr_gt"};
        issue(e);
        drain("zthr_gt");

        vec_mixed();
        e.lv = put(put(put('0, 1, 16'hFFFA), 3, 16'd1), 9, 16'hF801);
        e.oc = put(put(put('0, 1, 16'hFFE8), 8, 16'd4), 12, 16'hE004);
        e.nz = 1'b1;
        e.lp = 4'd9;
        e.name = "mixed";
        issue(e);
        drain("mixed");

        // start re-pulsed mid-run must be ignored
        d0 = done_count;
        vec_dc100(16'd100);
        e = '{lv: put('0, 0, 16'd10), oc: put('0, 0, 16'd100),
              nz: 1'b1, lp: 4'd0, name: "repulse"};
        issue(e);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain("repulse");
        repeat (25) @(negedge clk);
        check("repulse_done_count", done_count - d0, 1);

        // reset mid-run aborts with no done
        vec_mixed();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_pre_nz", bus.nz, 1);
        rst = 1'b1;
        #1;
        check("abort_levels", bus.levels, 0);
        check("abort_out_coeffs", bus.out_coeffs, 0);
        check("abort_nz", bus.nz, 0);
        check("abort_last_pos", bus.last_pos, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_count;
        repeat (25) @(negedge clk);
        check("abort_no_done", done_count - d0, 0);

        vec_c15(32'd4);
        e = '{lv: put('0, 15, 16'd5), oc: put('0, 15, 16'd5),
              nz: 1'b1, lp: 4'd15, name: "after_rst"};
        issue(e);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
